// File: rtl/udp_pixel_rx_if.sv
// Byte stream from the MAC/PHY RX path into udp_pixel_rx.
// in_valid stays high for a whole frame and drops for at least one cycle between frames.
interface udp_pixel_rx_if;
  logic       in_valid;
  logic [7:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/udp_pixel_rx.sv
// UDP pixel receiver: validates Ethernet/IPv4/UDP headers and writes the payload to VRAM.
// Define UDP_PIXEL_RX_FCS_CHECK_EN to add a CRC-32 check of the frame FCS.
module udp_pixel_rx #(
  parameter logic [47:0] MY_MAC        = 48'hdeadbeef0123,
  parameter logic [31:0] MY_IP         = 32'hc0a80102,
  parameter logic [15:0] UDP_LEN       = 16'd1448,
  parameter int          PAYLOAD_BYTES = 1437
) (
  input  logic          clk,
  input  logic          rstn,
  udp_pixel_rx_if.slave rx,
  output logic          busy,
  output logic          hdr_valid,
  output logic [15:0]   segment_num,
  output logic [7:0]    index_clone,
  output logic [7:0]    aux,
  output logic [23:0]   startaddr,
  output logic          pix_we,
  output logic [23:0]   pix_addr,
  output logic [7:0]    pix_data,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [2:0]    err_code
);
  localparam logic [11:0] LAST_IDX = 12'(45 + PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAY, TAIL, DRAIN} state_t;

  state_t      state, state_nx;
  logic [11:0] cnt;
  logic        mac_uc, mac_bc, mac_uc_nx, mac_bc_nx;
  logic        in_frame;
  logic [23:0] addr_ptr;
  logic        hdr_act, hdr_fail, chk_en, mac_chk;
  logic        pix_fire, end_evt, end_ok;
  logic [7:0]  exp_byte;
  logic [2:0]  fail_code, end_code;

  // busy ignores the post-reset drain so that every output is 0 out of reset.
  assign busy    = in_frame;
  assign hdr_act = rx.in_valid && (state == IDLE || state == HDR);

  always_comb begin
    chk_en    = 1'b0;
    mac_chk   = 1'b0;
    exp_byte  = 8'h00;
    fail_code = 3'd0;
    hdr_fail  = 1'b0;
    case (cnt)
      12'd0:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[47:40]; end
      12'd1:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[39:32]; end
      12'd2:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[31:24]; end
      12'd3:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[23:16]; end
      12'd4:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[15:8];  end
      12'd5:  begin mac_chk = 1'b1; fail_code = 3'd1; exp_byte = MY_MAC[7:0];   end
      12'd12: begin chk_en = 1'b1; fail_code = 3'd2; exp_byte = 8'h08; end
      12'd13: begin chk_en = 1'b1; fail_code = 3'd2; exp_byte = 8'h00; end
      12'd14: begin chk_en = 1'b1; fail_code = 3'd2; exp_byte = 8'h45; end
      12'd23: begin chk_en = 1'b1; fail_code = 3'd3; exp_byte = 8'h11; end
      12'd30: begin chk_en = 1'b1; fail_code = 3'd4; exp_byte = MY_IP[31:24]; end
      12'd31: begin chk_en = 1'b1; fail_code = 3'd4; exp_byte = MY_IP[23:16]; end
      12'd32: begin chk_en = 1'b1; fail_code = 3'd4; exp_byte = MY_IP[15:8];  end
      12'd33: begin chk_en = 1'b1; fail_code = 3'd4; exp_byte = MY_IP[7:0];   end
      12'd38: begin chk_en = 1'b1; fail_code = 3'd5; exp_byte = UDP_LEN[15:8]; end
      12'd39: begin chk_en = 1'b1; fail_code = 3'd5; exp_byte = UDP_LEN[7:0];  end
      default: ;
    endcase
    mac_uc_nx = mac_uc && (rx.in_data == exp_byte);
    mac_bc_nx = mac_bc && (rx.in_data == 8'hff);
    if (hdr_act) begin
      if (mac_chk && !mac_uc_nx && !mac_bc_nx)
        hdr_fail = 1'b1;
      else if (chk_en && rx.in_data != exp_byte)
        hdr_fail = 1'b1;
    end
  end

`ifdef UDP_PIXEL_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc;
  logic [2:0]  tail_cnt;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Register runs over FCS bytes too; a clean frame leaves the fixed CRC-32 residue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc      <= '1;
      tail_cnt <= 3'd0;
    end else if (state_nx == IDLE) begin
      crc      <= '1;
      tail_cnt <= 3'd0;
    end else begin
      if (rx.in_valid)
        crc <= crc_step(crc, rx.in_data);
      if (state == TAIL && rx.in_valid && tail_cnt != 3'd4)
        tail_cnt <= tail_cnt + 3'd1;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    pix_fire = 1'b0;
    end_evt  = 1'b0;
    end_ok   = 1'b0;
    end_code = err_code;
    case (state)
      IDLE: if (rx.in_valid) state_nx = hdr_fail ? DRAIN : HDR;
      HDR: begin
        if (!rx.in_valid) begin
          state_nx = IDLE;
          end_evt  = 1'b1;
          end_code = 3'd6;
        end else if (hdr_fail)
          state_nx = DRAIN;
        else if (cnt == 12'd44)
          state_nx = PAY;
      end
      PAY: begin
        if (!rx.in_valid) begin
          state_nx = IDLE;
          end_evt  = 1'b1;
          end_code = 3'd6;
        end else begin
          pix_fire = 1'b1;
          if (cnt == LAST_IDX) state_nx = TAIL;
        end
      end
      TAIL: begin
        if (!rx.in_valid) begin
          state_nx = IDLE;
          end_evt  = 1'b1;
`ifdef UDP_PIXEL_RX_FCS_CHECK_EN
          if (tail_cnt < 3'd4)
            end_code = 3'd6;
          else if (crc != CRC_RESIDUE)
            end_code = 3'd7;
          else begin
            end_ok   = 1'b1;
            end_code = 3'd0;
          end
`else
          end_ok   = 1'b1;
          end_code = 3'd0;
`endif
        end
      end
      DRAIN: begin
        if (!rx.in_valid) begin
          state_nx = IDLE;
          end_evt  = in_frame;
        end
      end
      default: state_nx = DRAIN;
    endcase
  end

  // Reset parks in DRAIN so a frame cut by reset is never mistaken for a fresh one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= DRAIN;
      cnt         <= 12'd0;
      mac_uc      <= 1'b1;
      mac_bc      <= 1'b1;
      in_frame    <= 1'b0;
      addr_ptr    <= 24'd0;
      hdr_valid   <= 1'b0;
      segment_num <= 16'd0;
      index_clone <= 8'd0;
      aux         <= 8'd0;
      startaddr   <= 24'd0;
      pix_we      <= 1'b0;
      pix_addr    <= 24'd0;
      pix_data    <= 8'd0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      state     <= state_nx;
      hdr_valid <= (state == HDR) && rx.in_valid && !hdr_fail && (cnt == 12'd44);
      pix_we    <= pix_fire;
      frame_ok  <= end_evt && end_ok;
      frame_err <= end_evt && !end_ok;

      if (state_nx == IDLE) begin
        cnt      <= 12'd0;
        mac_uc   <= 1'b1;
        mac_bc   <= 1'b1;
        in_frame <= 1'b0;
      end else begin
        if (rx.in_valid && cnt != 12'hfff) cnt <= cnt + 12'd1;
        if (hdr_act) begin
          mac_uc <= mac_uc_nx;
          mac_bc <= mac_bc_nx;
        end
        if (state == IDLE && rx.in_valid) in_frame <= 1'b1;
      end

      if (state == IDLE && rx.in_valid)
        err_code <= hdr_fail ? fail_code : 3'd0;
      else if (state == HDR && hdr_fail)
        err_code <= fail_code;
      else if (end_evt)
        err_code <= end_ok ? 3'd0 : end_code;

      if (hdr_act) begin
        case (cnt)
          12'd34: segment_num[15:8]  <= rx.in_data;
          12'd35: segment_num[7:0]   <= rx.in_data;
          12'd36: index_clone        <= rx.in_data;
          12'd37: aux                <= rx.in_data;
          12'd42: startaddr[23:16]   <= rx.in_data;
          12'd43: startaddr[15:8]    <= rx.in_data;
          12'd44: begin
            startaddr[7:0] <= rx.in_data;
            addr_ptr       <= {startaddr[23:8], rx.in_data};
          end
          default: ;
        endcase
      end

      if (pix_fire) begin
        pix_data <= rx.in_data;
        pix_addr <= addr_ptr;
        addr_ptr <= addr_ptr + 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_udp_pixel_rx.sv
// Scoreboard bench for udp_pixel_rx: random and directed frames against a byte-level reference model.
module tb_udp_pixel_rx;
  localparam int          P      = 1437;
  localparam logic [47:0] MY_MAC = 48'hdeadbeef0123;
  localparam logic [31:0] MY_IP  = 32'hc0a80102;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy, hdr_valid, pix_we, frame_ok, frame_err;
  logic [15:0] segment_num;
  logic [7:0]  index_clone, aux, pix_data;
  logic [23:0] startaddr, pix_addr;
  logic [2:0]  err_code;

  udp_pixel_rx_if rx_if ();

  udp_pixel_rx dut (
    .clk(clk), .rstn(rstn), .rx(rx_if),
    .busy(busy), .hdr_valid(hdr_valid), .segment_num(segment_num),
    .index_clone(index_clone), .aux(aux), .startaddr(startaddr),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [15:0] seg; logic [7:0] idx; logic [7:0] aux; logic [23:0] sa; } hdr_t;
  typedef struct { logic ok; logic [2:0] code; } res_t;
  typedef struct {
    logic [47:0] dmac; logic [15:0] etype; logic [7:0] verihl; logic [7:0] proto;
    logic [31:0] dip;  logic [15:0] ulen;  logic [15:0] seg;   logic [7:0] idx;
    logic [7:0]  aux;  logic [23:0] sa;    bit rand_pix;       int corrupt_k; int trunc_len;
  } cfg_t;

  wr_t  wr_q[$];
  hdr_t hdr_q[$];
  res_t res_q[$];
  logic [7:0] frame_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic cfg_t good_cfg();
    cfg_t c;
    c.dmac = MY_MAC; c.etype = 16'h0800; c.verihl = 8'h45; c.proto = 8'h11;
    c.dip = MY_IP; c.ulen = 16'd1448; c.seg = 16'h0003; c.idx = 8'd2; c.aux = 8'd7;
    c.sa = 24'h000100; c.rand_pix = 0; c.corrupt_k = -1; c.trunc_len = 0;
    return c;
  endfunction

  task automatic build_frame(input cfg_t c);
    logic [31:0] r;
    logic [7:0]  b;
    frame_q.delete();
    for (int i = 0; i < 45; i++) frame_q.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) frame_q[i] = 8'(c.dmac >> (8 * (5 - i)));
    frame_q[12] = c.etype[15:8]; frame_q[13] = c.etype[7:0];
    frame_q[14] = c.verihl;      frame_q[23] = c.proto;
    for (int i = 0; i < 4; i++) frame_q[30 + i] = 8'(c.dip >> (8 * (3 - i)));
    frame_q[34] = c.seg[15:8];   frame_q[35] = c.seg[7:0];
    frame_q[36] = c.idx;         frame_q[37] = c.aux;
    frame_q[38] = c.ulen[15:8];  frame_q[39] = c.ulen[7:0];
    frame_q[42] = c.sa[23:16];   frame_q[43] = c.sa[15:8];  frame_q[44] = c.sa[7:0];
    for (int k = 0; k < P; k++) frame_q.push_back(c.rand_pix ? 8'($urandom) : 8'(k));
    // Ethernet FCS: reflected CRC-32, complemented, sent LSB first.
    r = 32'hffffffff;
    foreach (frame_q[i]) begin
      b = frame_q[i];
      for (int j = 0; j < 8; j++)
        r = (r[0] ^ b[j]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    r = ~r;
    frame_q.push_back(r[7:0]);   frame_q.push_back(r[15:8]);
    frame_q.push_back(r[23:16]); frame_q.push_back(r[31:24]);
    if (c.corrupt_k >= 0) frame_q[45 + c.corrupt_k] = frame_q[45 + c.corrupt_k] ^ 8'h04;
    if (c.trunc_len > 0)
      while (frame_q.size() > c.trunc_len) void'(frame_q.pop_back());
  endtask

  // Reference model: walk the received bytes in order, the first broken header rule wins.
  task automatic push_expected(input cfg_t c, input bit expect_end);
    int L, npix;
    logic [2:0] code;
    bit uc, bc;
    logic [7:0] want;
    wr_t  w;
    hdr_t h;
    res_t r;
    L = frame_q.size(); code = 3'd0; uc = 1; bc = 1;
    for (int i = 0; i < L && i < 45 && code == 3'd0; i++) begin
      if (i < 6) begin
        want = 8'(MY_MAC >> (8 * (5 - i)));
        uc = uc && (frame_q[i] == want);
        bc = bc && (frame_q[i] == 8'hff);
        if (!uc && !bc) code = 3'd1;
      end
      else if ((i == 12 && frame_q[i] != 8'h08) || (i == 13 && frame_q[i] != 8'h00) ||
               (i == 14 && frame_q[i] != 8'h45)) code = 3'd2;
      else if (i == 23 && frame_q[i] != 8'h11) code = 3'd3;
      else if (i >= 30 && i <= 33 && frame_q[i] != 8'(MY_IP >> (8 * (33 - i)))) code = 3'd4;
      else if ((i == 38 && frame_q[i] != 8'h05) || (i == 39 && frame_q[i] != 8'hA8)) code = 3'd5;
    end
    if (code == 3'd0 && L >= 45) begin
      h.seg = c.seg; h.idx = c.idx; h.aux = c.aux; h.sa = c.sa;
      hdr_q.push_back(h);
    end
    if (code == 3'd0) begin
      npix = (L - 45 > P) ? P : L - 45;
      for (int k = 0; k < npix; k++) begin
        w.addr = 24'(c.sa + 24'(k));
        w.data = frame_q[45 + k];
        wr_q.push_back(w);
      end
      if (L < 45 + P) code = 3'd6;
`ifdef UDP_PIXEL_RX_FCS_CHECK_EN
      else if (L - 45 - P < 4) code = 3'd6;
      else if (c.corrupt_k >= 0) code = 3'd7;
`endif
    end
    if (expect_end) begin
      r.ok = (code == 3'd0); r.code = code;
      res_q.push_back(r);
    end
  endtask

  task automatic apply_stimulus(input int gap);
    foreach (frame_q[i]) begin
      @(negedge clk);
      if (i == 10) check_output("busy_in_frame", 32'(busy), 32'd1);
      rx_if.in_valid = 1'b1;
      rx_if.in_data  = frame_q[i];
    end
    @(negedge clk);
    rx_if.in_valid = 1'b0;
    rx_if.in_data  = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic run_frame(input cfg_t c, input int gap);
    build_frame(c);
    push_expected(c, 1'b1);
    apply_stimulus(gap);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, header or end pulse.
  always @(negedge clk) begin
    wr_t  ew;
    hdr_t eh;
    res_t er;
    if (rstn) begin
      if (pix_we) begin
        if (wr_q.size() == 0) check_output("spurious_write", 32'(wr_q.size()), 32'd1);
        else begin
          ew = wr_q.pop_front();
          check_output("pix_addr", 32'(pix_addr), 32'(ew.addr));
          check_output("pix_data", 32'(pix_data), 32'(ew.data));
        end
      end
      if (hdr_valid) begin
        if (hdr_q.size() == 0) check_output("spurious_hdr_valid", 32'(hdr_q.size()), 32'd1);
        else begin
          eh = hdr_q.pop_front();
          check_output("segment_num", 32'(segment_num), 32'(eh.seg));
          check_output("index_clone", 32'(index_clone), 32'(eh.idx));
          check_output("aux", 32'(aux), 32'(eh.aux));
          check_output("startaddr", 32'(startaddr), 32'(eh.sa));
        end
      end
      if (frame_ok || frame_err) begin
        if (res_q.size() == 0) check_output("spurious_end_pulse", 32'(res_q.size()), 32'd1);
        else begin
          er = res_q.pop_front();
          check_output("frame_ok", 32'(frame_ok), 32'(er.ok));
          check_output("frame_err", 32'(frame_err), 32'(!er.ok));
          check_output("err_code", 32'(err_code), 32'(er.code));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_t c;
    int ftype;
    rx_if.in_valid = 1'b0;
    rx_if.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check_output("rst_pix_we", 32'(pix_we), 32'd0);
    check_output("rst_frame_ok", 32'(frame_ok), 32'd0);
    check_output("rst_frame_err", 32'(frame_err), 32'd0);
    check_output("rst_err_code", 32'(err_code), 32'd0);
    check_output("rst_startaddr", 32'(startaddr), 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    c = good_cfg(); run_frame(c, 4);
    check_output("idle_busy", 32'(busy), 32'd0);
    c = good_cfg(); c.dmac = 48'h020000000001; run_frame(c, 4);
    c = good_cfg(); c.dmac = 48'hffffffffffff; c.seg = 16'h1234; run_frame(c, 4);
    c = good_cfg(); c.proto = 8'h06; run_frame(c, 4);
    c = good_cfg(); c.ulen = 16'h05AC; run_frame(c, 4);
    c = good_cfg(); c.trunc_len = 45 + 101; run_frame(c, 4);
    c = good_cfg(); c.sa = 24'hFFFFFE; c.rand_pix = 1; run_frame(c, 4);
    c = good_cfg(); c.corrupt_k = 700; run_frame(c, 4);
    c = good_cfg(); c.trunc_len = 45 + P + 2; run_frame(c, 4);
    c = good_cfg(); c.sa = 24'h123456; run_frame(c, 1);
    c = good_cfg(); c.sa = 24'h654321; c.rand_pix = 1; run_frame(c, 4);

    // Reset in the middle of the payload: writes stop at once and no end pulse follows.
    c = good_cfg(); c.sa = 24'h004000; c.rand_pix = 1; c.trunc_len = 80;
    build_frame(c);
    push_expected(c, 1'b0);
    foreach (frame_q[i]) begin
      @(negedge clk);
      rx_if.in_valid = 1'b1;
      rx_if.in_data  = frame_q[i];
    end
    @(negedge clk);
    rx_if.in_data = 8'h5a;
    #2 rstn = 1'b0;
    #1 check_output("reset_pix_we", 32'(pix_we), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx_if.in_data = 8'($urandom);
    end
    @(negedge clk);
    rx_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    c = good_cfg(); c.sa = 24'h00ABCD; run_frame(c, 4);

    for (int n = 0; n < 8; n++) begin
      c = good_cfg();
      c.seg = 16'($urandom); c.idx = 8'($urandom); c.aux = 8'($urandom);
      c.sa = 24'($urandom); c.rand_pix = 1;
      ftype = $urandom_range(0, 7);
      case (ftype)
        1: c.dmac = {16'($urandom), 32'($urandom)};
        2: c.etype = 16'($urandom);
        3: c.verihl = 8'($urandom);
        4: c.proto = 8'($urandom);
        5: c.dip = 32'($urandom);
        6: c.ulen = 16'($urandom);
        7: c.trunc_len = $urandom_range(1, 45 + P + 3);
        default: ;
      endcase
      run_frame(c, $urandom_range(1, 3));
    end

    repeat (10) @(negedge clk);
    check_output("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check_output("hdr_q_drained", 32'(hdr_q.size()), 32'd0);
    check_output("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
